// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-rate divider, horizontal/vertical position counters
// and registered sync/blanking decode with frame-aligned start and stop.
module vga_timing_ctrl #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       disp_active_o,
   output logic [9:0] xcol_o,
   output logic [9:0] yrow_o,
   output logic       pix_tick_o,
   output logic       frame_start_o,
   output logic       busy_o
);

   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0]       HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]       HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]       VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]       VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   generate
      if (H_TOT > 1024 || V_TOT > 1024) begin : g_tot_check
         $error("vga_timing_ctrl: H_TOT and V_TOT must not exceed 1024");
      end
      if (CLK_DIV == 0) begin : g_div_check
         $error("vga_timing_ctrl: CLK_DIV must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_d;
   logic [9:0]       x_q;
   logic [9:0]       x_d;
   logic [9:0]       y_q;
   logic [9:0]       y_d;
   logic             adv;
   logic             x_wrap;
   logic             frame_end;
   logic             running_d;
   logic             hsync_d;
   logic             vsync_d;
   logic             disp_d;
   logic             tick_d;
   logic             fstart_d;

   // The divider wrap is the only event that moves the raster position.
   assign adv       = (state_q != S_IDLE) && (div_cnt == DIV_LAST);
   assign x_wrap    = adv && (x_q == H_LAST);
   assign frame_end = x_wrap && (y_q == V_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (en_i) state_d = S_RUN;
         S_RUN:   if (!en_i) state_d = S_DRAIN;
         S_DRAIN: begin
            if (en_i) begin
               state_d = S_RUN;
            end else if (frame_end) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counters restart from zero when leaving IDLE and are parked at zero in IDLE.
   always_comb begin
      div_d = '0;
      x_d   = '0;
      y_d   = '0;
      if (state_q != S_IDLE && state_d != S_IDLE) begin
         div_d = adv ? '0 : div_cnt + 1'b1;
         x_d   = x_q;
         y_d   = y_q;
         if (adv) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
            if (x_wrap) begin
               y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end
         end
      end
   end

   // Decoding from next-state values keeps every registered output aligned
   // with the position it describes.
   assign running_d = (state_d != S_IDLE);

   always_comb begin
      hsync_d  = ~SYNC_POL;
      vsync_d  = ~SYNC_POL;
      disp_d   = 1'b0;
      tick_d   = 1'b0;
      fstart_d = 1'b0;
      if (running_d) begin
         if (x_d >= HS_FIRST && x_d <= HS_LAST) hsync_d = SYNC_POL;
         if (y_d >= VS_FIRST && y_d <= VS_LAST) vsync_d = SYNC_POL;
         disp_d   = (x_d < H_VIS) && (y_d < V_VIS);
         tick_d   = (div_d == '0);
         fstart_d = tick_d && (x_d == 10'd0) && (y_d == 10'd0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_cnt       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         hsync_o       <= ~SYNC_POL;
         vsync_o       <= ~SYNC_POL;
         disp_active_o <= 1'b0;
         pix_tick_o    <= 1'b0;
         frame_start_o <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         div_cnt       <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_o       <= hsync_d;
         vsync_o       <= vsync_d;
         disp_active_o <= disp_d;
         pix_tick_o    <= tick_d;
         frame_start_o <= fstart_d;
         busy_o        <= running_d;
      end
   end

   assign xcol_o = x_q;
   assign yrow_o = y_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced raster (16x12 positions, 3 clocks per pixel)
// plus a CLK_DIV=1, positive-sync instance.
module tb_vga_timing_ctrl;

   localparam int D     = 3;
   localparam int HA    = 8;
   localparam int HFP   = 2;
   localparam int HS    = 3;
   localparam int HBP   = 3;
   localparam int VA    = 6;
   localparam int VFP   = 2;
   localparam int VS    = 2;
   localparam int VBP   = 2;
   localparam int HT    = HA + HFP + HS + HBP;
   localparam int VT    = VA + VFP + VS + VBP;
   localparam int ROW   = HT * D;
   localparam int FRAME = HT * VT * D;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       da;
      logic [9:0] x;
      logic [9:0] y;
      logic       tick;
      logic       fs;
      logic       busy;
   } obs_t;

   typedef struct {
      int   t;
      obs_t e;
   } vec_t;

   localparam obs_t RST_OBS   = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};
   localparam obs_t START_OBS = '{1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1};

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       en_i;
   logic       hsync_o, vsync_o, disp_active_o, pix_tick_o, frame_start_o, busy_o;
   logic [9:0] xcol_o, yrow_o;
   logic       en1;
   logic       hs1, vs1, da1, tick1, fs1, busy1;
   logic [9:0] x1, y1;

   int checks   = 0;
   int failures = 0;
   int m_mode   = 0;
   int m_t      = 0;

   always #5 clk_i = ~clk_i;

   vga_timing_ctrl #(
      .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
   ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .disp_active_o(disp_active_o),
      .xcol_o(xcol_o), .yrow_o(yrow_o), .pix_tick_o(pix_tick_o),
      .frame_start_o(frame_start_o), .busy_o(busy_o)
   );

   vga_timing_ctrl #(
      .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1)
   ) u_dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en1),
      .hsync_o(hs1), .vsync_o(vs1), .disp_active_o(da1),
      .xcol_o(x1), .yrow_o(y1), .pix_tick_o(tick1),
      .frame_start_o(fs1), .busy_o(busy1)
   );

   // Reference: one linear cycle count within the frame; position derived arithmetically.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_mode <= 0;
         m_t    <= 0;
      end else begin
         case (m_mode)
            0: if (en_i) begin
               m_mode <= 1;
               m_t    <= 0;
            end
            1: begin
               m_t <= (m_t + 1) % FRAME;
               if (!en_i) m_mode <= 2;
            end
            default: begin
               if (en_i) begin
                  m_mode <= 1;
                  m_t    <= (m_t + 1) % FRAME;
               end else if (m_t == FRAME - 1) begin
                  m_mode <= 0;
                  m_t    <= 0;
               end else begin
                  m_t <= m_t + 1;
               end
            end
         endcase
      end
   end

   function automatic obs_t model_obs(int mode, int t);
      obs_t o;
      int   x;
      int   y;
      o = RST_OBS;
      if (mode != 0) begin
         x      = (t / D) % HT;
         y      = t / ROW;
         o.hs   = !(x >= HA + HFP && x < HA + HFP + HS);
         o.vs   = !(y >= VA + VFP && y < VA + VFP + VS);
         o.da   = (x < HA) && (y < VA);
         o.x    = 10'(x);
         o.y    = 10'(y);
         o.tick = (t % D) == 0;
         o.fs   = (t == 0);
         o.busy = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.hs   = hsync_o;
      o.vs   = vsync_o;
      o.da   = disp_active_o;
      o.x    = xcol_o;
      o.y    = yrow_o;
      o.tick = pix_tick_o;
      o.fs   = frame_start_o;
      o.busy = busy_o;
      return o;
   endfunction

   function automatic vec_t mk(int t, int x, int y, bit hs, bit vs, bit da, bit tk, bit fs);
      vec_t v;
      v.t = t;
      v.e = '{hs, vs, da, 10'(x), 10'(y), tk, fs, 1'b1};
      return v;
   endfunction

   task automatic chk_obs(string name, obs_t a, obs_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h want %h (model t=%0d)", name, a, e, m_t);
      end
   endtask

   task automatic chk_int(string name, int a, int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      chk_obs("model", dut_obs(), model_obs(m_mode, m_t));
   endtask

   task automatic run_to(int target);
      int n = 0;
      while (m_t != target && n < 4 * FRAME) begin
         step();
         n++;
      end
      chk_int("run_to", m_t, target);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[19];
      int   cur;
      int   n;
      int   fs_at;
      int   dropped;
      int   hs_w;
      int   tick_low;

      tbl[0]  = mk(0,   0,  0,  1, 1, 1, 1, 1);
      tbl[1]  = mk(1,   0,  0,  1, 1, 1, 0, 0);
      tbl[2]  = mk(2,   0,  0,  1, 1, 1, 0, 0);
      tbl[3]  = mk(3,   1,  0,  1, 1, 1, 1, 0);
      tbl[4]  = mk(21,  7,  0,  1, 1, 1, 1, 0);
      tbl[5]  = mk(24,  8,  0,  1, 1, 0, 1, 0);
      tbl[6]  = mk(29,  9,  0,  1, 1, 0, 0, 0);
      tbl[7]  = mk(30,  10, 0,  0, 1, 0, 1, 0);
      tbl[8]  = mk(38,  12, 0,  0, 1, 0, 0, 0);
      tbl[9]  = mk(39,  13, 0,  1, 1, 0, 1, 0);
      tbl[10] = mk(47,  15, 0,  1, 1, 0, 0, 0);
      tbl[11] = mk(48,  0,  1,  1, 1, 1, 1, 0);
      tbl[12] = mk(261, 7,  5,  1, 1, 1, 1, 0);
      tbl[13] = mk(288, 0,  6,  1, 1, 0, 1, 0);
      tbl[14] = mk(384, 0,  8,  1, 0, 0, 1, 0);
      tbl[15] = mk(477, 15, 9,  1, 0, 0, 1, 0);
      tbl[16] = mk(480, 0,  10, 1, 1, 0, 1, 0);
      tbl[17] = mk(575, 15, 11, 1, 1, 0, 0, 0);
      tbl[18] = mk(576, 0,  0,  1, 1, 1, 1, 1);

      // Reset held with en_i high
      rst_i = 1'b1;
      en_i  = 1'b1;
      en1   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         chk_obs("reset", dut_obs(), RST_OBS);
      end
      chk_int("d1_reset", int'({hs1, vs1, da1, tick1, fs1, busy1, x1, y1}), 0);
      rst_i = 1'b0;
      step();

      // Table of positions measured in cycles from the start edge
      cur = 0;
      for (int i = 0; i < 19; i++) begin
         while (cur < tbl[i].t) begin
            step();
            cur++;
         end
         chk_obs($sformatf("vec%0d", i), dut_obs(), tbl[i].e);
      end

      // Drop en_i mid-frame: raster finishes the frame, then IDLE
      run_to(3 * ROW + 5 * D);
      en_i = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (busy_o && n < 2 * FRAME);
      chk_int("drain_len", n, FRAME - (3 * ROW + 5 * D));
      chk_obs("drain_idle", dut_obs(), RST_OBS);
      step();
      chk_obs("drain_stay", dut_obs(), RST_OBS);

      // Re-raise en_i during drain: no gap, next frame on schedule
      en_i = 1'b1;
      step();
      chk_obs("reraise_start", dut_obs(), START_OBS);
      fs_at   = -1;
      dropped = 0;
      for (int i = 1; i <= FRAME; i++) begin
         step();
         if (i == 2 * ROW) en_i = 1'b0;
         if (i == 7 * ROW) en_i = 1'b1;
         if (!busy_o) dropped++;
         if (frame_start_o && fs_at < 0) fs_at = i;
      end
      chk_int("reraise_period", fs_at, FRAME);
      chk_int("reraise_busy", dropped, 0);

      // Asynchronous reset in the middle of a frame
      run_to(4 * ROW + 6 * D);
      #2;
      rst_i = 1'b1;
      #1;
      chk_obs("rst_async", dut_obs(), RST_OBS);
      step();
      chk_obs("rst_hold", dut_obs(), RST_OBS);
      rst_i = 1'b0;
      step();
      chk_obs("rst_restart", dut_obs(), START_OBS);

      // Single-cycle en_i pulse runs exactly one frame
      en_i = 1'b0;
      n = 0;
      while (busy_o && n < 2 * FRAME) begin
         step();
         n++;
      end
      chk_int("pulse_idle", int'(busy_o), 0);
      en_i = 1'b1;
      step();
      en_i = 1'b0;
      n = 1;
      while (busy_o && n < 2 * FRAME) begin
         step();
         if (busy_o) n++;
      end
      chk_int("pulse_len", n, FRAME);

      // CLK_DIV=1, positive sync polarity
      en1 = 1'b1;
      step();
      chk_int("d1_start", int'({fs1, busy1, tick1, da1, hs1, x1, y1}), 'b11110 << 20);
      fs_at    = -1;
      hs_w     = 0;
      tick_low = 0;
      for (int i = 1; i <= 2 * HT * VT; i++) begin
         step();
         if (busy1 && !tick1) tick_low++;
         if (fs1 && fs_at < 0) fs_at = i;
         if (i < HT && hs1) hs_w++;
      end
      chk_int("d1_tick", tick_low, 0);
      chk_int("d1_period", fs_at, HT * VT);
      chk_int("d1_hsync_w", hs_w, HS);
      en1 = 1'b0;

      // Randomized run request and occasional reset, checked every cycle
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 119) == 0) en_i = ~en_i;
         if ($urandom_range(0, 799) == 0) begin
            rst_i = 1'b1;
            step();
            rst_i = 1'b0;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
